// File: rtl/dwconv_pkg.sv
// Shared definitions for the depthwise 3x3 convolution sequencer.
// Holds the sequencer FSM state encoding, the cell's tap count and default accumulator width,
// and a width helper that keeps single-valued coordinate fields one bit wide.
package dwconv_pkg;

    localparam int KERNELS = 9;
    localparam int ACC_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // $clog2(1) is 0, which would give a zero-width port when a dimension is 1.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dwconv_win_counter.sv
// Nested window coordinate counter: col fastest, then row, then channel; wraps to 0 after the last window.
// Ports: clr zeroes all coordinates, inc advances by one window, last flags the final window of a channel sweep.
// Single-cycle update; holds whenever inc is low, so the caller owns all stall handling.
module dwconv_win_counter #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CH    = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_b,
    input  logic                                        clr,
    input  logic                                        inc,
    output logic [dwconv_pkg::clog2_min1(IMG_W)-1:0]    col,
    output logic [dwconv_pkg::clog2_min1(IMG_H)-1:0]    row,
    output logic [dwconv_pkg::clog2_min1(CH)-1:0]       ch,
    output logic                                        last
);
    import dwconv_pkg::*;

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int CH_W  = clog2_min1(CH);

    // A valid 3x3 window's top-left corner stops two short of each edge.
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_W - 3);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_H - 3);
    localparam logic [CH_W-1:0]  CH_MAX  = CH_W'(CH - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q,  ch_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (clr) begin
            col_d = '0;
            row_d = '0;
            ch_d  = '0;
        end else if (inc) begin
            if (col_q == COL_MAX) begin
                col_d = '0;
                if (row_q == ROW_MAX) begin
                    row_d = '0;
                    ch_d  = (ch_q == CH_MAX) ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            ch_q  <= ch_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign ch   = ch_q;
    assign last = (col_q == COL_MAX) && (row_q == ROW_MAX) && (ch_q == CH_MAX);

endmodule

// File: rtl/dwconv_3_3_1_ctrl.sv
// Sequencer for the 9-tap depthwise 3x3 stride-1 cell: issues one window read per cycle,
// enables the cell, adds bias to the two partial sums and streams results out (valid/ready).
// Latency read->result 3 cycles; a stalled output (valid & !ready) freezes the whole pipeline.
// Ports: start/cfg_bias/busy/done control, rd_* window buffer request, mac_en/psum0/psum1 cell side,
// out_data/out_valid/out_ready/out_last result stream.
// Build option DWCONV_CTRL_RELU_EN: clamp negative results to 0.
module dwconv_3_3_1_ctrl #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int CH    = 8,
    parameter int ACC_W = dwconv_pkg::ACC_W
) (
    input  logic                                        clk,
    input  logic                                        rst_b,
    input  logic                                        start,
    input  logic signed [ACC_W-1:0]                     cfg_bias,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        rd_en,
    output logic [dwconv_pkg::clog2_min1(IMG_H)-1:0]    rd_row,
    output logic [dwconv_pkg::clog2_min1(IMG_W)-1:0]    rd_col,
    output logic [dwconv_pkg::clog2_min1(CH)-1:0]       rd_ch,
    output logic                                        mac_en,
    input  logic signed [ACC_W-1:0]                     psum0,
    input  logic signed [ACC_W-1:0]                     psum1,
    output logic signed [ACC_W-1:0]                     out_data,
    output logic                                        out_valid,
    input  logic                                        out_ready,
    output logic                                        out_last
);
    import dwconv_pkg::*;

    state_e state_q, state_d;
    logic   busy_q, busy_d, done_q, done_d;
    logic   v1_q, v1_d, l1_q, l1_d;
    logic   v2_q, v2_d, l2_q, l2_d;
    logic   out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic signed [ACC_W-1:0] bias_q, bias_d, out_data_q, out_data_d;
    logic signed [ACC_W-1:0] sum, result;
    logic   stall, issue, cnt_clr, cnt_last;

    // Every stage moves in lockstep, so a blocked output is the only source of backpressure.
    assign stall   = out_valid_q & ~out_ready;
    assign issue   = (state_q == ST_RUN) & ~stall;
    assign cnt_clr = (state_q == ST_IDLE) & start;

    dwconv_win_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .CH    (CH)
    ) u_cnt (
        .clk   (clk),
        .rst_b (rst_b),
        .clr   (cnt_clr),
        .inc   (issue),
        .col   (rd_col),
        .row   (rd_row),
        .ch    (rd_ch),
        .last  (cnt_last)
    );

    assign sum = psum0 + psum1 + bias_q;

    always_comb begin
        result = sum;
`ifdef DWCONV_CTRL_RELU_EN
        if (sum[ACC_W-1]) begin
            result = '0;
        end
`endif
    end

    always_comb begin
        v1_d        = v1_q;
        l1_d        = l1_q;
        v2_d        = v2_q;
        l2_d        = l2_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        if (!stall) begin
            v1_d        = issue;
            l1_d        = issue & cnt_last;
            v2_d        = v1_q;
            l2_d        = l1_q;
            out_valid_d = v2_q;
            out_last_d  = l2_q;
            if (v2_q) begin
                out_data_d = result;
            end
        end

        state_d = state_q;
        bias_d  = bias_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    bias_d  = cfg_bias;
                end
            end
            ST_RUN: begin
                if (issue && cnt_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Looking at next-cycle valids lets done land right after the final handshake.
                if (!v1_d && !v2_d && !out_valid_d) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= ST_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bias_q      <= '0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            bias_q      <= bias_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            v2_q        <= v2_d;
            l2_q        <= l2_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = issue;
    assign mac_en    = v1_q & ~stall;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dwconv_3_3_1_ctrl.sv
// Bench for dwconv_3_3_1_ctrl on a 5x4 map with 2 channels (12 windows per run).
// A small window-buffer/cell model feeds psums that encode the window coordinate,
// so result values also prove issue order.
module tb_dwconv_3_3_1_ctrl;
    localparam int IMG_W = 4;
    localparam int IMG_H = 5;
    localparam int CH    = 2;
    localparam int ACC_W = 32;
    localparam int NWIN  = (IMG_H - 2) * (IMG_W - 2) * CH;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b1;
    logic signed [ACC_W-1:0] cfg_bias = '0;
    logic signed [ACC_W-1:0] psum0, psum1, out_data;
    logic busy, done, rd_en, mac_en, out_valid, out_last;
    logic [$clog2(IMG_H)-1:0] rd_row;
    logic [$clog2(IMG_W)-1:0] rd_col;
    logic [$clog2(CH)-1:0]    rd_ch;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dwconv_3_3_1_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .CH(CH), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .cfg_bias(cfg_bias),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_ch(rd_ch), .mac_en(mac_en), .psum0(psum0), .psum1(psum1),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    function automatic int code(input int c, input int r, input int k);
        return c * 100 + r * 10 + k;
    endfunction

    // Window buffer latches coordinates on rd_en; cell registers psums on en.
    int  p0_base = 0;
    int  p1_base = 0;
    bit  use_coord = 1'b0;
    logic [$clog2(IMG_H)-1:0] b_row;
    logic [$clog2(IMG_W)-1:0] b_col;
    logic [$clog2(CH)-1:0]    b_ch;

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            b_row <= '0; b_col <= '0; b_ch <= '0;
            psum0 <= '0; psum1 <= '0;
        end else begin
            if (rd_en) begin
                b_row <= rd_row; b_col <= rd_col; b_ch <= rd_ch;
            end
            if (mac_en) begin
                psum0 <= p0_base + (use_coord ? code(int'(b_ch), int'(b_row), int'(b_col)) : 0);
                psum1 <= p1_base;
            end
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int bias;
        int p0;
        int p1;
        bit coord;
        int stall_at;
        int stall_len;
        bit poke;
    } vec_t;

    vec_t vt[6];

    // Runs one full job from a start pulse and checks every result, the issue order and timing.
    task automatic run_vec(input int id, input vec_t v);
        int exp_d[$]; int exp_c[$]; int rd_q[$]; int got_d[$]; bit got_l[$];
        int first_rd, first_mac, first_ov, last_hs, done_k, busy_bad, stall_bad, hold_bad;
        bit prev_stall;
        logic signed [ACC_W-1:0] prev_d, e;
        logic prev_l;
        for (int c = 0; c < CH; c++)
            for (int r = 0; r < IMG_H - 2; r++)
                for (int k = 0; k < IMG_W - 2; k++) begin
                    e = v.p0 + v.p1 + v.bias + (v.coord ? code(c, r, k) : 0);
`ifdef DWCONV_CTRL_RELU_EN
                    if (e < 0) e = '0;
`endif
                    exp_d.push_back(int'(e));
                    exp_c.push_back(code(c, r, k));
                end
        p0_base = v.p0; p1_base = v.p1; use_coord = v.coord; cfg_bias = v.bias;
        first_rd = -1; first_mac = -1; first_ov = -1; last_hs = -5; done_k = -1;
        busy_bad = 0; stall_bad = 0; hold_bad = 0; prev_stall = 1'b0;
        prev_d = '0; prev_l = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 300 && done_k < 0; k++) begin
            out_ready = (k < v.stall_at) || (k >= v.stall_at + v.stall_len);
            start = v.poke && (k == 4);
            if (v.poke && k == 4) cfg_bias = v.bias + 1000;
            #1;
            if (rd_en) begin
                rd_q.push_back(code(int'(rd_ch), int'(rd_row), int'(rd_col)));
                if (first_rd < 0) first_rd = k;
            end
            if (mac_en && first_mac < 0) first_mac = k;
            if (out_valid && first_ov < 0) first_ov = k;
            if (prev_stall && (!out_valid || out_data != prev_d || out_last != prev_l)) hold_bad++;
            prev_stall = out_valid && !out_ready;
            prev_d = out_data; prev_l = out_last;
            if (prev_stall && (rd_en || mac_en)) stall_bad++;
            if (out_valid && out_ready) begin
                got_d.push_back(int'(out_data));
                got_l.push_back(out_last);
                last_hs = k;
            end
            if (done) begin
                done_k = k;
                if (busy) busy_bad++;
            end else if (!busy) begin
                busy_bad++;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; out_ready = 1'b1;
        chk($sformatf("v%0d done_seen", id), longint'(done_k >= 0), 1);
        chk($sformatf("v%0d n_results", id), got_d.size(), NWIN);
        for (int i = 0; i < NWIN && i < got_d.size(); i++) begin
            chk($sformatf("v%0d data[%0d]", id, i), got_d[i], exp_d[i]);
            chk($sformatf("v%0d last[%0d]", id, i), got_l[i], (i == NWIN - 1) ? 1 : 0);
        end
        chk($sformatf("v%0d n_reads", id), rd_q.size(), NWIN);
        for (int i = 0; i < NWIN && i < rd_q.size(); i++)
            chk($sformatf("v%0d coord[%0d]", id, i), rd_q[i], exp_c[i]);
        chk($sformatf("v%0d first_rd", id), first_rd, 0);
        chk($sformatf("v%0d first_mac", id), first_mac, 1);
        chk($sformatf("v%0d first_valid", id), first_ov, 3);
        chk($sformatf("v%0d done_after_last", id), done_k, last_hs + 1);
        chk($sformatf("v%0d run_cycles", id), done_k, NWIN + 3 + v.stall_len);
        chk($sformatf("v%0d busy_window", id), busy_bad, 0);
        chk($sformatf("v%0d stall_quiet", id), stall_bad, 0);
        chk($sformatf("v%0d stall_hold", id), hold_bad, 0);
        #1;
        chk($sformatf("v%0d done_pulse", id), done, 0);
        chk($sformatf("v%0d busy_after", id), busy, 0);
        @(posedge clk); #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " busy"}, busy, 0);
        chk({nm, " done"}, done, 0);
        chk({nm, " rd_en"}, rd_en, 0);
        chk({nm, " mac_en"}, mac_en, 0);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " out_last"}, out_last, 0);
        chk({nm, " out_data"}, out_data, 0);
        chk({nm, " coord"}, {rd_ch, rd_row, rd_col}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          bias         p0    p1  coord stall_at len poke
        vt[0] = '{3,           5,    4,  1'b0, 1000,    0,  1'b0};
        vt[1] = '{-7,          1000, 20, 1'b1, 1000,    0,  1'b0};
        vt[2] = '{11,          0,    0,  1'b1, 6,       5,  1'b0};
        vt[3] = '{50,          7,    -2, 1'b1, 1000,    0,  1'b1};
        vt[4] = '{2147483647,  1,    0,  1'b0, 1000,    0,  1'b0};
        vt[5] = '{-100,        30,   10, 1'b0, 1000,    0,  1'b0};

        #12;
        chk_all_zero("reset");
        @(negedge clk); rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) run_vec(i, vt[i]);

        // Reset in the middle of a run while results are streaming.
        p0_base = 5; p1_base = 4; use_coord = 1'b0; cfg_bias = 3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrun out_valid", out_valid, 1);
        chk("midrun busy", busy, 1);
        rst_b = 1'b0;
        #1;
        chk_all_zero("midrun_reset");
        @(posedge clk); #1;
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset done[%0d]", i), done, 0);
            chk($sformatf("post_reset busy[%0d]", i), busy, 0);
        end
        run_vec(6, vt[1]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
